// File: rtl/opl_slot_scheduler.sv
// Operator slot sequencer for an OPL2-style FM core: walks NUM_SLOTS slots of
// CYCLES_PER_SLOT pipeline cycles once per sample request, flagging overruns.
module opl_slot_scheduler #(
    parameter int NUM_SLOTS       = 18,
    parameter int CYCLES_PER_SLOT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic       sample_clk_en,
    input  logic       clear_overrun,
    output logic       busy,
    output logic [4:0] slot,
    output logic [3:0] stage,
    output logic       slot_start,
    output logic [3:0] channel,
    output logic       op_type,
    output logic       sample_done,
    output logic       overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST_SLOT  = 5'(NUM_SLOTS - 1);
    localparam logic [3:0] LAST_STAGE = 4'(CYCLES_PER_SLOT - 1);

    state_t     state, state_nx;
    logic [4:0] slot_nx;
    logic [3:0] stage_nx;
    logic       done_nx;
    logic       overrun_nx;
    logic       last_stage;
    logic       last_cycle;

    assign last_stage = (stage == LAST_STAGE);
    assign last_cycle = (state == RUN) && last_stage && (slot == LAST_SLOT);

    always_comb begin
        state_nx   = state;
        slot_nx    = slot;
        stage_nx   = stage;
        done_nx    = 1'b0;
        overrun_nx = overrun;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (sample_clk_en) begin
                        state_nx = RUN;
                        slot_nx  = '0;
                        stage_nx = '0;
                    end
                end
                RUN: begin
                    // A request landing on the final cycle restarts immediately.
                    if (last_cycle) begin
                        done_nx  = 1'b1;
                        slot_nx  = '0;
                        stage_nx = '0;
                        state_nx = sample_clk_en ? RUN : IDLE;
                    end else if (last_stage) begin
                        stage_nx = '0;
                        slot_nx  = slot + 5'd1;
                    end else begin
                        stage_nx = stage + 4'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase

            if ((state == RUN) && sample_clk_en && !last_cycle) begin
                overrun_nx = 1'b1;
            end else if (clear_overrun) begin
                overrun_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            slot        <= '0;
            stage       <= '0;
            sample_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nx;
            slot        <= slot_nx;
            stage       <= stage_nx;
            sample_done <= done_nx;
            overrun     <= overrun_nx;
        end
    end

    assign busy       = (state == RUN);
    assign slot_start = busy && (stage == '0);

    // Slots come in groups of six covering three channels: mod ops then carrier ops.
    assign channel = 4'((slot / 5'd6) * 5'd3 + (slot % 5'd3));
    assign op_type = (slot % 5'd6) >= 5'd3;

endmodule

// File: tb/tb_opl_slot_scheduler.sv
// Bench for opl_slot_scheduler: a default instance and a 6-slot/1-cycle instance
// share stimulus and are checked each cycle against a position-counting model.
module tb_opl_slot_scheduler;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_en = 1'b0;
    logic sample_clk_en = 1'b0;
    logic clear_overrun = 1'b0;

    logic       busy_a, slot_start_a, op_a, done_a, ovr_a;
    logic [4:0] slot_a;
    logic [3:0] stage_a, ch_a;
    logic       busy_b, slot_start_b, op_b, done_b, ovr_b;
    logic [4:0] slot_b;
    logic [3:0] stage_b, ch_b;

    always #5 clk = ~clk;

    opl_slot_scheduler dut_a (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .sample_clk_en(sample_clk_en), .clear_overrun(clear_overrun),
        .busy(busy_a), .slot(slot_a), .stage(stage_a), .slot_start(slot_start_a),
        .channel(ch_a), .op_type(op_a), .sample_done(done_a), .overrun(ovr_a)
    );

    opl_slot_scheduler #(.NUM_SLOTS(6), .CYCLES_PER_SLOT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .sample_clk_en(sample_clk_en), .clear_overrun(clear_overrun),
        .busy(busy_b), .slot(slot_b), .stage(stage_b), .slot_start(slot_start_b),
        .channel(ch_b), .op_type(op_b), .sample_done(done_b), .overrun(ovr_b)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a sequence is just a count of enabled cycles since it started.
    int unsigned ns[2]  = '{18, 6};
    int unsigned cps[2] = '{4, 1};
    bit          m_busy[2];
    int unsigned m_pos[2];
    bit          m_done[2];
    bit          m_ovr[2];

    bit          lb, ld, lo;
    int unsigned lp;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            lb = m_busy[i];
            lp = m_pos[i];
            lo = m_ovr[i];
            ld = 1'b0;
            if (!reset_n) begin
                lb = 1'b0;
                lp = 0;
                lo = 1'b0;
            end else if (clk_en) begin
                if (lb && sample_clk_en && (lp + 1 != ns[i] * cps[i])) lo = 1'b1;
                else if (clear_overrun) lo = 1'b0;
                if (lb) begin
                    lp++;
                    if (lp == ns[i] * cps[i]) begin
                        ld = 1'b1;
                        lp = 0;
                        lb = sample_clk_en;
                    end
                end else if (sample_clk_en) begin
                    lb = 1'b1;
                    lp = 0;
                end
            end
            m_busy[i] <= lb;
            m_pos[i]  <= lp;
            m_done[i] <= ld;
            m_ovr[i]  <= lo;
        end
    end

    task automatic cmp(input int i, input logic bz, input logic [4:0] sl, input logic [3:0] st,
                       input logic ss, input logic [3:0] ch, input logic op,
                       input logic dn, input logic ov);
        int unsigned es  = m_pos[i] / cps[i];
        int unsigned est = m_pos[i] % cps[i];
        int unsigned grp = es / 6;
        int unsigned w   = es % 6;
        chk($sformatf("busy[%0d]", i), bz, m_busy[i]);
        chk($sformatf("slot[%0d]", i), sl, es);
        chk($sformatf("stage[%0d]", i), st, est);
        chk($sformatf("slot_start[%0d]", i), ss, m_busy[i] && est == 0);
        chk($sformatf("channel[%0d]", i), ch, grp * 3 + w % 3);
        chk($sformatf("op_type[%0d]", i), op, w / 3);
        chk($sformatf("sample_done[%0d]", i), dn, m_done[i]);
        chk($sformatf("overrun[%0d]", i), ov, m_ovr[i]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, busy_a, slot_a, stage_a, slot_start_a, ch_a, op_a, done_a, ovr_a);
            cmp(1, busy_b, slot_b, stage_b, slot_start_b, ch_b, op_b, done_b, ovr_b);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic advance(input int n);
        repeat (n) step();
    endtask

    int ch_tbl[18] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 6, 7, 8};
    int op_tbl[18] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    initial begin
        int nss, nb, nss_b, nbusy, nbusy_b, ndone, w, mode;

        reset_n = 1'b0;
        step();
        chk_on = 1'b1;
        advance(2);
        chk("rst_busy", busy_a, 0);
        chk("rst_slot", slot_a, 0);
        chk("rst_stage", stage_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_channel", ch_a, 0);
        chk("rst_op", op_a, 0);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        step();

        // Single full sample period at full rate
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        nss = 0; nb = 0; nss_b = 0;
        for (int k = 0; k < 72; k++) begin
            chk("t1_busy", busy_a, 1);
            chk("t1_slot", slot_a, k / 4);
            chk("t1_stage", stage_a, k % 4);
            if (slot_start_a) nss++;
            if (k % 4 == 0) begin
                chk("t1_map_ch", ch_a, ch_tbl[k / 4]);
                chk("t1_map_op", op_a, op_tbl[k / 4]);
            end
            if (busy_b) nb++;
            if (slot_start_b) nss_b++;
            step();
        end
        chk("t1_end_busy", busy_a, 0);
        chk("t1_done", done_a, 1);
        step();
        chk("t1_done_width", done_a, 0);
        chk("t1_slot_starts", nss, 18);
        chk("t1_b_busy_cycles", nb, 6);
        chk("t1_b_slot_starts", nss_b, 6);

        // clk_en every third clk
        nbusy = 0; nbusy_b = 0; ndone = 0;
        for (int c = 0; c < 400; c++) begin
            clk_en        = (c % 3 == 0);
            sample_clk_en = (c == 0);
            step();
            if (busy_a) nbusy++;
            if (busy_b) nbusy_b++;
            if (done_a) ndone++;
        end
        chk("t2_busy_clks", nbusy, 216);
        chk("t2_b_busy_clks", nbusy_b, 18);
        chk("t2_done_clks", ndone, 1);
        clk_en = 1'b1;
        sample_clk_en = 1'b0;
        step();

        // Overrun, set-wins, back-to-back restart, clear
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        advance(20);
        chk("t3_slot5", slot_a, 5);
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        chk("t3_overrun", ovr_a, 1);
        chk("t3_unaffected", slot_a, 5);
        advance(9);
        sample_clk_en = 1'b1;
        clear_overrun = 1'b1;
        step();
        sample_clk_en = 1'b0;
        clear_overrun = 1'b0;
        chk("t3_set_wins", ovr_a, 1);
        advance(40);
        chk("t3_final_slot", slot_a, 17);
        chk("t3_final_stage", stage_a, 3);
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        chk("t3_b2b_busy", busy_a, 1);
        chk("t3_b2b_slot", slot_a, 0);
        chk("t3_b2b_stage", stage_a, 0);
        chk("t3_b2b_done", done_a, 1);
        chk("t3_b2b_overrun", ovr_a, 1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        chk("t3_cleared", ovr_a, 0);
        w = 0;
        while (busy_a && w < 200) begin
            step();
            w++;
        end
        chk("t3_idle_in_time", busy_a, 0);

        // Reset mid-sequence
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        advance(8);
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        chk("t4_overrun_set", ovr_a, 1);
        advance(27);
        chk("t4_slot9", slot_a, 9);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t4_busy", busy_a, 0);
        chk("t4_slot", slot_a, 0);
        chk("t4_stage", stage_a, 0);
        chk("t4_overrun", ovr_a, 0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            if (done_a) ndone++;
            step();
        end
        chk("t4_no_done", ndone, 0);
        sample_clk_en = 1'b1;
        step();
        sample_clk_en = 1'b0;
        chk("t4_restart_busy", busy_a, 1);
        chk("t4_restart_slot", slot_a, 0);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            mode = (c / 500) % 3;
            case (mode)
                0:       clk_en = 1'b1;
                1:       clk_en = $urandom_range(0, 1) == 1;
                default: clk_en = (c % 3 == 0);
            endcase
            sample_clk_en = $urandom_range(0, 59) == 0;
            clear_overrun = $urandom_range(0, 24) == 0;
            reset_n       = $urandom_range(0, 699) != 0;
            step();
        end
        reset_n = 1'b1;
        sample_clk_en = 1'b0;
        clear_overrun = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opl_slot_scheduler.md
OPL_SLOT_SCHEDULER -- requirements
Module: opl_slot_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 18, number of operator slots sequenced per sample period; legal range 6..18, multiple of 6.
REQ-002 Parameter CYCLES_PER_SLOT, default 4, clk_en cycles spent on each slot (operator pipeline depth); legal range 1..16.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset; synchronous and active-low.
REQ-005 clk_en  input  1  clock enable; all state advances only on clk edges where clk_en=1.
REQ-006 sample_clk_en  input  1  sample-period start request; honoured only when clk_en=1.
REQ-007 clear_overrun  input  1  clears the overrun flag; honoured only when clk_en=1.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 slot  output  5  current operator slot index, 0..NUM_SLOTS-1.
REQ-010 stage  output  4  current cycle within slot, 0..CYCLES_PER_SLOT-1.
REQ-011 slot_start  output  1  high on the first cycle (stage=0) of each slot while busy.
REQ-012 channel  output  4  OPL2 channel owning the current slot.
REQ-013 op_type  output  1  0 = modulator, 1 = carrier.
REQ-014 sample_done  output  1  single-clk pulse when the final slot of a sample period completes.
REQ-015 overrun  output  1  sticky flag: sample request arrived while busy.

Function
REQ-016 Two states SHALL exist: IDLE and RUN.
REQ-017 IDLE -> RUN on a clk_en cycle with sample_clk_en=1; on that edge slot and stage SHALL load 0.
REQ-018 In RUN, each clk_en cycle SHALL increment stage; when stage=CYCLES_PER_SLOT-1, stage SHALL wrap to 0 and slot SHALL increment.
REQ-019 When slot=NUM_SLOTS-1 and stage=CYCLES_PER_SLOT-1 on a clk_en cycle, state SHALL return to IDLE, slot and stage SHALL load 0, and sample_done SHALL be high for exactly the next clk cycle.
REQ-020 A RUN period SHALL last exactly NUM_SLOTS*CYCLES_PER_SLOT clk_en cycles (72 at defaults).
REQ-021 sample_clk_en on the final RUN clk_en cycle (REQ-019 condition) SHALL be accepted back-to-back: state stays RUN, slot/stage load 0, sample_done still pulses, overrun unchanged.
REQ-022 sample_clk_en on any other RUN clk_en cycle SHALL be dropped and SHALL set overrun; the current sequence is unaffected.
REQ-023 overrun SHALL remain set until clear_overrun on a clk_en cycle; if set and clear coincide, set SHALL win.
REQ-024 slot_start SHALL equal busy AND stage=0, derived from registers (no combinational path from inputs).
REQ-025 channel SHALL equal (slot/6)*3 + (slot mod 3); op_type SHALL equal 1 when (slot mod 6)>=3, else 0; both valid in all states (0/0 in IDLE since slot=0).
REQ-026 With CYCLES_PER_SLOT=1, stage SHALL be constant 0 and slot SHALL advance every RUN clk_en cycle.
REQ-027 With clk_en=0 all registers SHALL hold, except sample_done which SHALL deassert after its single clk cycle.

Reset
REQ-028 reset_n=0 at a clk edge SHALL force IDLE, slot=0, stage=0, busy=0, sample_done=0, overrun=0, regardless of clk_en.
REQ-029 Reset during RUN SHALL abort the sequence with no sample_done pulse; the first sample_clk_en after release starts from slot 0.

Verification
REQ-030 Defaults, clk_en=1, one sample_clk_en pulse -> busy high 72 cycles, slot_start 18 times, slot 0..17 in order, sample_done one pulse the cycle after slot=17/stage=3.
REQ-031 Slot mapping sweep -> slots 0,3,6,9,12,15 map to channels 0,0,3,3,6,6 with op_type 0,1,0,1,0,1; slot 17 -> channel 8, op_type 1.
REQ-032 clk_en asserted every 3rd clk -> RUN lasts 216 clk cycles, state frozen between enables, sample_done exactly 1 clk wide.
REQ-033 sample_clk_en at slot=5 -> overrun=1, sequence still ends at 72 cycles; sample_clk_en on final cycle -> immediate restart at slot 0, overrun unchanged; clear_overrun -> overrun=0.
REQ-034 reset_n low at slot=9 for one clk -> next cycle busy=0, slot=0, no sample_done, overrun=0.
REQ-035 CYCLES_PER_SLOT=1, NUM_SLOTS=6 -> busy 6 cycles, slot_start high every busy cycle.
